// File: rtl/hpdl1414_scan_driver_pkg.sv
// hpdl1414_scan_driver_pkg: shared FSM states and charset constants for the HPDL-1414 scan driver
package hpdl1414_scan_driver_pkg;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CARETCHR = 8'h5f;
  localparam int DISPLAY_POSITIONS = 16;
endpackage

// File: rtl/hpdl1414_scan_driver_char_map.sv
// hpdl1414_scan_driver_char_map: combinational 8b buffer char to 7b HPDL-1414 charset map
module hpdl1414_scan_driver_char_map
  import hpdl1414_scan_driver_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [6:0] o_char
);
  // lower case 0x60..0x7E always has bit 5 set, so clearing it subtracts 0x20
  always_comb
    o_char = (i_char >= CHAR_SPACE && i_char <= CARETCHR) ? i_char[6:0] :
             (i_char >= 8'h60 && i_char <= 8'h7e) ? {i_char[6], 1'b0, i_char[4:0]} :
             CHAR_SPACE[6:0];
endmodule

// File: rtl/hpdl1414_scan_driver.sv
// hpdl1414_scan_driver: scans the 16-char buffer into four HPDL-1414 displays with timed WR# strobes
module hpdl1414_scan_driver
  import hpdl1414_scan_driver_pkg::*;
#(
  parameter int NUM_CHIPS    = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int WR_CYCLES    = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLINK_DIV    = 5000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  output logic                 o_read_enable,
  output logic [3:0]           o_read_address,
  input  logic [7:0]           i_read_data,
  output logic                 o_caret_strobe,
  output logic [6:0]           o_data,
  output logic [1:0]           o_addr,
  output logic [NUM_CHIPS-1:0] o_wr_n,
  output logic                 o_frame_done
);
  localparam int MAXC = (SETUP_CYCLES > WR_CYCLES ? SETUP_CYCLES : WR_CYCLES) > (HOLD_CYCLES > REFRESH_DIV ? HOLD_CYCLES : REFRESH_DIV) ?
                        (SETUP_CYCLES > WR_CYCLES ? SETUP_CYCLES : WR_CYCLES) : (HOLD_CYCLES > REFRESH_DIV ? HOLD_CYCLES : REFRESH_DIV);
  localparam int PW = $clog2(MAXC + 1);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0] LAST_POS = 4'(DISPLAY_POSITIONS - 1);
  state_t r_state, w_next;
  logic [PW-1:0] r_phase, w_limit;
  logic w_last;
  logic [3:0] r_pos;
  logic [6:0] r_data, w_char;
  logic [1:0] r_addr;
  logic [NUM_CHIPS-1:0] r_wr_n;
  logic r_frame_done, r_caret;
  logic [BW-1:0] r_blink;
  hpdl1414_scan_driver_char_map u_map (.i_char(i_read_data), .o_char(w_char));
  always_comb begin
    w_limit = r_state == S_SETUP  ? PW'(SETUP_CYCLES - 1) :
              r_state == S_STROBE ? PW'(WR_CYCLES - 1) :
              r_state == S_HOLD   ? PW'(HOLD_CYCLES - 1) : PW'(REFRESH_DIV - 1);
    w_last = r_phase == w_limit;
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_enable ? S_READ : S_IDLE;
      S_READ:   w_next = S_LATCH;
      S_LATCH:  w_next = S_SETUP;
      S_SETUP:  w_next = w_last ? S_STROBE : S_SETUP;
      S_STROBE: w_next = w_last ? S_HOLD : S_STROBE;
      S_HOLD:   w_next = !w_last ? S_HOLD : !i_enable ? S_IDLE : r_pos == LAST_POS ? S_GAP : S_READ;
      S_GAP:    w_next = !i_enable ? S_IDLE : w_last ? S_READ : S_GAP;
      default:  w_next = S_IDLE;
    endcase
  end
  // WR# is registered from the next state so the pulse is glitch-free and aligned with STROBE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_pos        <= '0;
      r_data       <= '0;
      r_addr       <= '0;
      r_wr_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_phase      <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_phase + 1'b1;
      r_pos        <= w_next == S_IDLE ? '0 : (r_state == S_HOLD && w_last) ? r_pos + 1'b1 : r_pos;
      r_data       <= r_state == S_LATCH ? w_char : r_data;
      r_addr       <= r_state == S_LATCH ? 2'd3 - r_pos[1:0] : r_addr;
      r_wr_n       <= w_next == S_STROBE ? ~(NUM_CHIPS'(1) << r_pos[3:2]) : '1;
      r_frame_done <= w_next == S_GAP && r_state != S_GAP;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blink <= '0;
      r_caret <= 1'b1;
    end else begin
      r_blink <= r_blink == BW'(BLINK_DIV - 1) ? '0 : r_blink + 1'b1;
      r_caret <= r_blink == BW'(BLINK_DIV - 1) ? ~r_caret : r_caret;
    end
  end
  assign o_read_enable  = r_state == S_READ;
  assign o_read_address = r_pos;
  assign o_caret_strobe = r_caret;
  assign o_data         = r_data;
  assign o_addr         = r_addr;
  assign o_wr_n         = r_wr_n;
  assign o_frame_done   = r_frame_done;
endmodule

// File: tb/tb_hpdl1414_scan_driver.sv
// tb_hpdl1414_scan_driver: directed/random frame scans checked against a buffer model and timeline rules
module tb_hpdl1414_scan_driver;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic re, caret, fd;
  logic [3:0] ra, wr_n;
  logic [6:0] data;
  logic [1:0] addr;
  logic [7:0] mem [16];
  int n_chk = 0, n_fail = 0, cyc = 0, fd_cnt = 0, rd_cnt = 0;
  always #5 clk = ~clk;
  hpdl1414_scan_driver #(.BLINK_DIV(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .o_read_enable(re), .o_read_address(ra),
    .i_read_data(rd_data), .o_caret_strobe(caret), .o_data(data), .o_addr(addr),
    .o_wr_n(wr_n), .o_frame_done(fd)
  );
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  // buffer model: registered read, data presented from the read cycle onward
  always @(negedge clk) begin
    if (re) begin
      rd_data = mem[ra];
      rd_cnt++;
    end
    if (fd) fd_cnt++;
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] ref_map(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h5f) return c[6:0];
    if (c >= 8'h60 && c <= 8'h7e) return 7'(c - 8'h20);
    return 7'h20;
  endfunction
  function automatic logic exp_caret();
    return ((cyc / 8) % 2) == 0;
  endfunction
  // mode 0: plain char; 1: drop enable in 2nd strobe cycle; 2: reset in 2nd strobe cycle
  task automatic do_char(input int k, input int mode, output int waited);
    logic [6:0] e;
    logic [3:0] wl;
    logic [1:0] a;
    e = ref_map(mem[k]);
    wl = ~(4'b0001 << (k / 4));
    a = 2'(3 - k % 4);
    waited = 0;
    tick();
    while (!re && waited < 1100) begin
      tick();
      waited++;
    end
    chk("read_en", re, 1);
    chk("read_addr", ra, k);
    tick();
    chk("latch_single_read", re, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("setup", {wr_n, addr, data}, {4'hf, a, e});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("strobe", {wr_n, addr, data}, {wl, a, e});
      if (i == 1 && mode == 1) en = 1'b0;
      if (i == 1 && mode == 2) begin
        rst = 1'b1;
        tick();
        chk("rst_mid_strobe", {wr_n, re, fd, caret}, {4'hf, 1'b0, 1'b0, 1'b1});
        tick();
        chk("rst_state", {wr_n, re, ra, fd, caret, addr, data}, {4'hf, 1'b0, 4'h0, 1'b0, 1'b1, 2'b0, 7'b0});
        rst = 1'b0;
        return;
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold", {wr_n, addr, data}, {4'hf, a, e});
    end
  endtask
  initial begin
    int w, r0;
    for (int k = 0; k < 16; k++) mem[k] = 8'(8'h41 + k);
    tick();
    tick();
    chk("reset", {wr_n, re, ra, fd, caret, addr, data}, {4'hf, 1'b0, 4'h0, 1'b0, 1'b1, 2'b0, 7'b0});
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("blink_idle", caret, exp_caret());
      chk("idle_no_read", re, 0);
    end
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      do_char(k, 0, w);
      chk("char_spacing_f1", w, 0);
    end
    mem[0] = 8'h61; mem[1] = 8'h7e; mem[2] = 8'h7f;
    mem[3] = 8'h0a; mem[4] = 8'h5f; mem[5] = 8'hc1;
    for (int k = 6; k < 16; k++) mem[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 16; k++) begin
      do_char(k, 0, w);
      chk("char_spacing_f2", w, k == 0 ? 1000 : 0);
      if (k == 0) chk("frame_done_f1", fd_cnt, 1);
    end
    for (int k = 0; k < 16; k++) mem[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 5; k++) begin
      do_char(k, 0, w);
      chk("char_spacing_f3", w, k == 0 ? 1000 : 0);
      if (k == 0) chk("frame_done_f2", fd_cnt, 2);
    end
    do_char(5, 1, w);
    r0 = rd_cnt;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("blink_disabled", caret, exp_caret());
      chk("disabled_wr_idle", wr_n, 4'hf);
    end
    chk("no_read_disabled", rd_cnt - r0, 0);
    en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      do_char(k, 0, w);
      chk("reenable_spacing", w, 0);
    end
    do_char(9, 2, w);
    do_char(0, 0, w);
    chk("restart_after_reset", w, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("blink_enabled", caret, exp_caret());
    end
    chk("frame_done_total", fd_cnt, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
